ds1822_responder: RTL and testbench
===================================

DS1822_RESPONDER -- requirements
Module: ds1822_responder

Interface
REQ-001 SHALL have parameter CLK_PER_US, default 2: clk cycles per microsecond.
REQ-002 SHALL have parameter ROM_ID, default 64'h5500000000000022: 64-bit ROM code, family byte 0x22 in bits [7:0].
REQ-003 SHALL have parameter CONV_US, default 1000: Convert T duration in microseconds.
REQ-004 SHALL have parameter CFG_BYTES, default 48'h10_0C_FF_7F_46_4B: scratchpad bytes 2..7 (TH, TL, config, reserved), byte 2 in bits [7:0].
REQ-005 SHALL have port clk, input, 1: sole clock.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port dq_in, input, 1: sensed 1-wire bus level, asynchronous.
REQ-008 SHALL have port dq_oe, output, 1: 1 = pull bus low; 0 = release.
REQ-009 SHALL have port temp, input, 16: temperature sample, latched at Convert T completion.
REQ-010 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-011 SHALL have port last_cmd, output, 8: most recent accepted function command.

Function
REQ-012 SHALL synchronise dq_in through two flops; all timing uses the synchronised level; a falling edge starts a slot.
REQ-013 SHALL count continuous low time; low >= 400 us in any state aborts the current transaction and enters PRES_WAIT.
REQ-014 PRES_WAIT SHALL wait for the bus to rise, wait 30 us, enter PRESENCE, assert dq_oe for 120 us, then enter ROM_CMD.
REQ-015 In RX states (ROM_CMD, FUNC_CMD), each falling edge SHALL sample the bus 30 us later; bits shift in LSB first; 8 bits form a byte.
REQ-016 In TX states, each falling edge SHALL transmit the current bit LSB first: bit 0 asserts dq_oe for 30 us from the edge; bit 1 leaves the bus released.
REQ-017 ROM_CMD SHALL decode 0xCC (Skip ROM) to FUNC_CMD and 0x33 (Read ROM) to ROM_TX; any other value goes to IDLE.
REQ-018 ROM_TX SHALL send the 64 bits of ROM_ID, then go to FUNC_CMD.
REQ-019 FUNC_CMD SHALL decode 0xBE to SCR_TX and 0x44 to CONV; any other value goes to IDLE. Accepted codes update last_cmd.
REQ-020 SCR_TX SHALL send 72 bits: latched temp LSB, temp MSB, CFG_BYTES[7:0]..[47:40], CRC byte; it then goes to IDLE.
REQ-021 CONV SHALL set busy for CONV_US*CLK_PER_US cycles and answer read slots with 0 while busy, 1 after.
REQ-022 On conversion completion, busy SHALL fall and temp SHALL be latched in that same cycle.
REQ-023 A conversion SHALL continue after the bus reset that follows it.
REQ-024 IDLE SHALL ignore all slots, keeping dq_oe = 0, until a bus reset is detected.
REQ-025 A slot falling edge arriving while dq_oe is self-asserted SHALL be ignored.
REQ-026 Falling edges closer than 30 us apart SHALL NOT corrupt the bit counter; each edge is one slot.
REQ-027 The latched temp register SHALL be 16 bits, with no arithmetic applied.

Reset
REQ-028 On rst: state = IDLE, dq_oe = 0, busy = 0, last_cmd = 0x00, latched temp = 0x0000, all counters = 0.
REQ-029 After rst, the first valid transaction SHALL require a bus reset pulse.

Configuration
REQ-030 With DS1822_CRC_EN defined, the CRC byte SHALL be the Dallas CRC-8 (x^8+x^5+x^4+1, init 0, LSB first) of scratchpad bytes 0..7.
REQ-031 The CRC SHALL be computed bit-serially as those bytes are transmitted.
REQ-032 Without DS1822_CRC_EN, the CRC byte SHALL be 0x00 and no CRC logic is present.

Verification
REQ-033 Bus low 480 us then released -> dq_oe rises 30 us +/- 1 cycle after release and stays high 120 us.
REQ-034 Reset, write 0x33, 64 read slots -> bits read equal ROM_ID LSB first (first byte 0x22).
REQ-035 temp=16'h0191: reset, 0xCC, 0x44, poll read slots -> 0 until busy falls, then 1.
REQ-036 Continuing REQ-035: then reset, 0xCC, 0xBE, 72 read slots -> bytes 91 01 4B 46 7F FF 0C 10, then a CRC byte matching the bench model with the macro (0x00 without).
REQ-037 A 480 us low after 20 bits of SCR_TX -> presence pulse; new 0xCC/0xBE restarts from byte 0.
REQ-038 Reset then ROM command 0xA5 -> dq_oe stays 0 for 16 further slots; last_cmd unchanged.

Source files
------------

// File: rtl/ds1822_responder.sv
// DS1822-style 1-wire slave: reset/presence, Skip/Read ROM, Convert T and Read Scratchpad.
// Define DS1822_CRC_EN to append a Dallas CRC-8 to the scratchpad; otherwise that byte is 0x00.
module ds1822_responder #(
  parameter int unsigned CLK_PER_US = 2,
  parameter logic [63:0] ROM_ID     = 64'h5500000000000022,
  parameter int unsigned CONV_US    = 1000,
  parameter logic [47:0] CFG_BYTES  = 48'h10_0C_FF_7F_46_4B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dq_in,
  output logic        dq_oe,
  input  logic [15:0] temp,
  output logic        busy,
  output logic [7:0]  last_cmd
);

  localparam int unsigned T30Cyc   = 30 * CLK_PER_US;
  localparam int unsigned T120Cyc  = 120 * CLK_PER_US;
  localparam int unsigned TRstCyc  = 400 * CLK_PER_US;
  localparam int unsigned TConvCyc = CONV_US * CLK_PER_US;
  // Presence delay is counted from the synchronised rise, so remove sync and output latency.
  localparam int unsigned TPresDly = T30Cyc - 3;

  typedef enum logic [2:0] {
    StIdle, StPresWait, StPresence, StRomCmd, StRomTx, StFuncCmd, StScrTx, StConv
  } state_e;

  state_e      state_q, state_d;
  logic        dq_s1_q, dq_s2_q, dq_prev_q;
  logic [31:0] low_cnt_q, low_cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] oe_tmr_q, oe_tmr_d;
  logic [31:0] conv_cnt_q, conv_cnt_d;
  logic        oe_q, oe_d;
  logic        slot_pend_q, slot_pend_d;
  logic        busy_q, busy_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  last_cmd_q, last_cmd_d;
  logic [15:0] temp_q, temp_d;
  logic [7:0]  crc_byte, rx_byte;
  logic [63:0] scratch;
  logic        fall, bus_rst, commit, commit_bit, tx_bit, tx_state;

`ifdef DS1822_CRC_EN
  logic [7:0] crc_q, crc_d;
  assign crc_byte = crc_q;
`else
  assign crc_byte = 8'h00;
`endif

  // Our own low drive can never look like a master slot.
  assign fall     = dq_prev_q & ~dq_s2_q & ~oe_q;
  assign bus_rst  = ~dq_s2_q && (low_cnt_q == TRstCyc - 1);
  assign scratch  = {CFG_BYTES, temp_q};
  assign tx_state = state_q inside {StRomTx, StScrTx, StConv};
  assign rx_byte  = {commit_bit, rx_q[7:1]};

  assign dq_oe    = oe_q;
  assign busy     = busy_q;
  assign last_cmd = last_cmd_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    oe_d        = oe_q;
    oe_tmr_d    = oe_tmr_q;
    slot_pend_d = slot_pend_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    busy_d      = busy_q;
    conv_cnt_d  = conv_cnt_q;
    temp_d      = temp_q;
    last_cmd_d  = last_cmd_q;
`ifdef DS1822_CRC_EN
    crc_d       = crc_q;
`endif
    commit      = 1'b0;
    commit_bit  = 1'b0;
    tx_bit      = 1'b1;

    if (dq_s2_q) low_cnt_d = '0;
    else if (low_cnt_q == TRstCyc) low_cnt_d = low_cnt_q;
    else low_cnt_d = low_cnt_q + 32'd1;

    // Conversion is independent of bus state so it survives a bus reset.
    if (busy_q) begin
      if (conv_cnt_q == TConvCyc - 1) begin
        busy_d     = 1'b0;
        temp_d     = temp;
        conv_cnt_d = '0;
      end else begin
        conv_cnt_d = conv_cnt_q + 32'd1;
      end
    end

    if (oe_q) begin
      if (oe_tmr_q == '0) oe_d = 1'b0;
      else oe_tmr_d = oe_tmr_q - 32'd1;
    end

    unique case (state_q)
      StPresWait: begin
        if (!dq_s2_q) begin
          tmr_d = '0;
        end else if (tmr_q == TPresDly) begin
          state_d  = StPresence;
          oe_d     = 1'b1;
          oe_tmr_d = T120Cyc - 1;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      StPresence: begin
        if (oe_tmr_q == '0) begin
          state_d     = StRomCmd;
          bit_cnt_d   = '0;
          slot_pend_d = 1'b0;
        end
      end
      StRomCmd, StFuncCmd: begin
        // A new edge closes any pending slot early so every edge counts as one bit.
        if (fall) begin
          if (slot_pend_q) commit = 1'b1;
          slot_pend_d = 1'b1;
          tmr_d       = '0;
        end else if (slot_pend_q) begin
          if (tmr_q == T30Cyc - 1) begin
            commit      = 1'b1;
            commit_bit  = dq_s2_q;
            slot_pend_d = 1'b0;
          end else begin
            tmr_d = tmr_q + 32'd1;
          end
        end
      end
      StRomTx: tx_bit = ROM_ID[bit_cnt_q[5:0]];
      StScrTx: tx_bit = bit_cnt_q[6] ? crc_byte[bit_cnt_q[2:0]] : scratch[bit_cnt_q[5:0]];
      StConv:  tx_bit = ~busy_q;
      default: ;
    endcase

    if (commit) begin
      rx_d = rx_byte;
      if (bit_cnt_q == 7'd7) begin
        bit_cnt_d = '0;
        if (state_q == StRomCmd) begin
          if (rx_byte == 8'hCC) begin
            state_d = StFuncCmd;
          end else begin
            state_d     = (rx_byte == 8'h33) ? StRomTx : StIdle;
            slot_pend_d = 1'b0;
          end
        end else begin
          slot_pend_d = 1'b0;
          if (rx_byte == 8'hBE) begin
            state_d    = StScrTx;
            last_cmd_d = rx_byte;
`ifdef DS1822_CRC_EN
            crc_d      = '0;
`endif
          end else if (rx_byte == 8'h44) begin
            state_d    = StConv;
            last_cmd_d = rx_byte;
            busy_d     = 1'b1;
            conv_cnt_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 7'd1;
      end
    end

    if (tx_state && fall) begin
      if (!tx_bit) begin
        oe_d     = 1'b1;
        oe_tmr_d = T30Cyc - 1;
      end
      if (state_q == StRomTx) begin
        if (bit_cnt_q == 7'd63) begin
          state_d   = StFuncCmd;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end else if (state_q == StScrTx) begin
`ifdef DS1822_CRC_EN
        if (!bit_cnt_q[6]) crc_d = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ tx_bit) ? 8'h8C : 8'h00);
`endif
        if (bit_cnt_q == 7'd71) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end
    end

    if (bus_rst) begin
      state_d     = StPresWait;
      tmr_d       = '0;
      oe_d        = 1'b0;
      oe_tmr_d    = '0;
      slot_pend_d = 1'b0;
      bit_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dq_s1_q     <= 1'b1;
      dq_s2_q     <= 1'b1;
      dq_prev_q   <= 1'b1;
      low_cnt_q   <= '0;
      tmr_q       <= '0;
      oe_tmr_q    <= '0;
      conv_cnt_q  <= '0;
      oe_q        <= 1'b0;
      slot_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      last_cmd_q  <= '0;
      temp_q      <= '0;
`ifdef DS1822_CRC_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dq_s1_q     <= dq_in;
      dq_s2_q     <= dq_s1_q;
      dq_prev_q   <= dq_s2_q;
      low_cnt_q   <= low_cnt_d;
      tmr_q       <= tmr_d;
      oe_tmr_q    <= oe_tmr_d;
      conv_cnt_q  <= conv_cnt_d;
      oe_q        <= oe_d;
      slot_pend_q <= slot_pend_d;
      busy_q      <= busy_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      last_cmd_q  <= last_cmd_d;
      temp_q      <= temp_d;
`ifdef DS1822_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_ds1822_responder.sv
// Bench for ds1822_responder: a 1-wire master model driving slots, with a queue of expected bits.
`timescale 1ns/1ps
module tb_ds1822_responder;

  localparam longint US = 20;  // ns per microsecond at 2 clocks per us

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_low = 1'b0;
  logic [15:0] temp = 16'h0191;
  logic        dq_in, dq_oe, busy;
  logic [7:0]  last_cmd;
  logic [63:0] rom_v = 64'h5500000000000022;
  logic [47:0] cfg_v = 48'h10_0C_FF_7F_46_4B;
  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_q[$];
  longint      last_slot_t = 0;
  logic        mon_en = 1'b0;
  logic        oe_seen = 1'b0;

  assign dq_in = ~(m_low | dq_oe);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mon_en) oe_seen <= 1'b0;
    else if (dq_oe) oe_seen <= 1'b1;
  end

  ds1822_responder #(
    .CLK_PER_US(2),
    .ROM_ID    (64'h5500000000000022),
    .CONV_US   (1000),
    .CFG_BYTES (48'h10_0C_FF_7F_46_4B)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dq_in   (dq_in),
    .dq_oe   (dq_oe),
    .temp    (temp),
    .busy    (busy),
    .last_cmd(last_cmd)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_bit(input logic b);
    cyc(1);
    last_slot_t = $time;
    m_low = 1'b1;
    if (b) begin
      cyc(6);
      m_low = 1'b0;
      cyc(124);
    end else begin
      cyc(120);
      m_low = 1'b0;
      cyc(10);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    cyc(1);
    last_slot_t = $time;
    m_low = 1'b1;
    cyc(6);
    m_low = 1'b0;
    cyc(18);
    b = dq_in;
    cyc(106);
  endtask

  // Returns clocks from release to dq_oe rising, and clocks dq_oe stayed high (0 on timeout).
  task automatic bus_reset(output int dly, output int len);
    cyc(1);
    m_low = 1'b1;
    cyc(960);
    m_low = 1'b0;
    dly = 0;
    len = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1);
      if (dq_oe === 1'b1) begin
        dly = i;
        break;
      end
    end
    if (dly != 0) begin
      len = 1;
      for (int i = 0; i < 400; i++) begin
        cyc(1);
        if (dq_oe !== 1'b1) break;
        len++;
      end
    end
    cyc(20);
  endtask

  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 64; i++) begin
      logic fb = c[0] ^ d[i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  task automatic test_reset();
    logic b, e;
    n_vec++;
    if (dq_oe !== 1'b0) begin n_err++; $display("FAIL reset_dq_oe: got %b want 0", dq_oe); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (last_cmd !== 8'h00) begin
      n_err++; $display("FAIL reset_last_cmd: got %h want 00", last_cmd);
    end
    // Without a bus reset the responder must stay silent.
    write_byte(8'h33);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b1);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL no_reset_slot%0d: got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_presence();
    int d, l;
    bus_reset(d, l);
    n_vec++;
    if (d < 59 || d > 61) begin
      n_err++; $display("FAIL pres_delay: got %0d clocks want 60+/-1", d);
    end
    n_vec++;
    if (l < 239 || l > 241) begin
      n_err++; $display("FAIL pres_len: got %0d clocks want 240+/-1", l);
    end
  endtask

  task automatic test_read_rom();
    int d, l;
    logic b, e;
    bus_reset(d, l);
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(rom_v[i]);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL rom_bit%0d: got %b want %b", i, b, e); end
    end
    n_vec++;
    if (last_cmd !== 8'h00) begin
      n_err++; $display("FAIL rom_last_cmd: got %h want 00", last_cmd);
    end
  endtask

  task automatic test_convert();
    int d, l;
    logic b, e;
    longint tend, ts;
    bus_reset(d, l);
    write_byte(8'hCC);
    write_byte(8'h44);
    tend = last_slot_t + 1030 * US;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL conv_busy: got %b want 1", busy); end
    n_vec++;
    if (last_cmd !== 8'h44) begin
      n_err++; $display("FAIL conv_last_cmd: got %h want 44", last_cmd);
    end
    for (int i = 0; i < 20; i++) begin
      ts = $time;
      // Slots landing right on the completion instant are ambiguous and left unchecked.
      if (ts > tend - 5 * US && ts < tend + 5 * US) begin
        read_bit(b);
      end else begin
        exp_q.push_back(ts > tend);
        read_bit(b);
        e = exp_q.pop_front();
        n_vec++;
        if (b !== e) begin n_err++; $display("FAIL conv_poll%0d: got %b want %b", i, b, e); end
      end
    end
  endtask

  task automatic test_conv_across_reset();
    int d, l;
    bus_reset(d, l);
    write_byte(8'hCC);
    write_byte(8'h44);
    bus_reset(d, l);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL conv_after_reset: got %b want 1", busy); end
    cyc(1000);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL conv_done: got %b want 0", busy); end
    temp = 16'hBEEF;
  endtask

  task automatic test_scratchpad();
    int d, l;
    logic b, e;
    logic [63:0] sp;
    logic [71:0] full;
    logic [7:0] crc;
    sp = {cfg_v, 16'h0191};
`ifdef DS1822_CRC_EN
    crc = crc8(sp);
`else
    crc = 8'h00;
`endif
    full = {crc, sp};
    bus_reset(d, l);
    write_byte(8'hCC);
    write_byte(8'hBE);
    n_vec++;
    if (last_cmd !== 8'hBE) begin
      n_err++; $display("FAIL scr_last_cmd: got %h want BE", last_cmd);
    end
    for (int i = 0; i < 72; i++) begin
      exp_q.push_back(full[i]);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin
        n_err++; $display("FAIL scr_byte%0d_bit%0d: got %b want %b", i / 8, i % 8, b, e);
      end
    end
  endtask

  task automatic test_abort();
    int d, l;
    logic b, e;
    logic [63:0] sp;
    sp = {cfg_v, 16'h0191};
    bus_reset(d, l);
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(sp[i]);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL abort_pre%0d: got %b want %b", i, b, e); end
    end
    bus_reset(d, l);
    n_vec++;
    if (d < 59 || d > 61) begin
      n_err++; $display("FAIL abort_pres: got %0d clocks want 60+/-1", d);
    end
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(sp[i]);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL abort_restart%0d: got %b want %b", i, b, e); end
    end
  endtask

  task automatic test_idle();
    int d, l;
    logic b, e;
    bus_reset(d, l);
    write_byte(8'hA5);
    mon_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(1'b1);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL idle_slot%0d: got %b want %b", i, b, e); end
    end
    n_vec++;
    if (oe_seen !== 1'b0) begin n_err++; $display("FAIL idle_dq_oe: got %b want 0", oe_seen); end
    mon_en = 1'b0;
    n_vec++;
    if (last_cmd !== 8'hBE) begin
      n_err++; $display("FAIL idle_last_cmd: got %h want BE", last_cmd);
    end
  endtask

  task automatic test_back_to_back();
    int d, l;
    logic b, e;
    logic [7:0] rest_v = 8'hCC;
    logic [63:0] sp;
    sp = {cfg_v, 16'h0191};
    bus_reset(d, l);
    // Bit 0 of 0xCC is a short slot cut off by the next edge 10 us later.
    cyc(1);
    m_low = 1'b1;
    cyc(4);
    m_low = 1'b0;
    cyc(15);
    for (int i = 1; i < 8; i++) write_bit(rest_v[i]);
    write_byte(8'hBE);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(sp[i]);
      read_bit(b);
      e = exp_q.pop_front();
      n_vec++;
      if (b !== e) begin n_err++; $display("FAIL b2b_bit%0d: got %b want %b", i, b, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc(5);
    rst = 1'b0;
    cyc(2);
    test_reset();
    test_presence();
    test_read_rom();
    test_convert();
    test_conv_across_reset();
    test_scratchpad();
    test_abort();
    test_idle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
